// File: rtl/id_ex_if.sv
// id_ex_if: decode-side inputs and EX-side outputs of the ID/EX pipeline stage.
//   master : drives hold/flush and the id_* slot; observes stall, ex_* and bubble_cnt
//   slave  : the stage itself
// id_ctrl / ex_ctrl layout (MSB first, bit 0 spare):
//   [19] reg_dst  [18] se  [17] reg_write  [16] alux_src  [15] aluy_src
//   [14:11] alu_ctrl  [10] mem_write  [9] mem_to_reg  [8:6] load_opt
//   [5:4] save_opt  [3] usigned  [2:1] rsv  [0] spare
interface id_ex_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) ();
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [19:0]      id_ctrl;
  logic [DW-1:0]    id_pc;
  logic [DW-1:0]    id_rs_data;
  logic [DW-1:0]    id_rt_data;
  logic [15:0]      id_imm;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic [4:0]       id_shamt;
  logic             id_uses_rt;
  logic             stall;
  logic             ex_valid;
  logic [19:0]      ex_ctrl;
  logic [DW-1:0]    ex_pc;
  logic [DW-1:0]    ex_rs_data;
  logic [DW-1:0]    ex_rt_data;
  logic [15:0]      ex_imm;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_shamt;
  logic [4:0]       ex_wreg;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output hold, flush, id_valid, id_ctrl, id_pc, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_shamt, id_uses_rt,
    input  stall, ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_shamt, ex_wreg, bubble_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_ctrl, id_pc, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_shamt, id_uses_rt,
    output stall, ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_shamt, ex_wreg, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_ex_if slave (hold/flush, id_* slot in; stall, ex_*, bubble_cnt out)
// One cycle ID->EX. A load in EX whose destination is read by the ID
// instruction stalls PC/IF-ID and inserts exactly one bubble into EX.
// Precedence per edge: hold (freeze) > flush (kill) > hazard (bubble, counted) > load.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  id_ex_if.slave bus
);
  localparam int RDST = 19;
  localparam int M2R  = 9;

  logic             ex_valid;
  logic [19:0]      ex_ctrl;
  logic [DW-1:0]    ex_pc, ex_rs_data, ex_rt_data;
  logic [15:0]      ex_imm;
  logic [4:0]       ex_rs, ex_rt, ex_shamt, ex_wreg;
  logic [CNT_W-1:0] bubble_cnt;

  logic [4:0] id_wreg;
  logic       haz;

  assign id_wreg = bus.id_ctrl[RDST] ? bus.id_rt : bus.id_rd;

  // Load in EX feeding an ID source; $0 is never a real dependence.
  assign haz = ex_valid & ex_ctrl[M2R] & (ex_wreg != 5'd0) & bus.id_valid &
               ((ex_wreg == bus.id_rs) | (bus.id_uses_rt & (ex_wreg == bus.id_rt)));

  // A flushed ID instruction never enters EX, so it cannot need a stall.
  assign bus.stall = bus.hold | (haz & ~bus.flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_shamt   <= '0;
      ex_wreg    <= '0;
      bubble_cnt <= '0;
    end else if (bus.hold) begin
      // freeze everything, including the counter
    end else if (bus.flush || haz) begin
      // Bubble: zero ctrl clears reg_write/mem_write, so no side effects.
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_shamt   <= '0;
      ex_wreg    <= '0;
      if (!bus.flush && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      ex_valid   <= bus.id_valid;
      ex_ctrl    <= bus.id_valid ? bus.id_ctrl : 20'd0;
      ex_pc      <= bus.id_pc;
      ex_rs_data <= bus.id_rs_data;
      ex_rt_data <= bus.id_rt_data;
      ex_imm     <= bus.id_imm;
      ex_rs      <= bus.id_rs;
      ex_rt      <= bus.id_rt;
      ex_shamt   <= bus.id_shamt;
      ex_wreg    <= id_wreg;
    end
  end

  assign bus.ex_valid   = ex_valid;
  assign bus.ex_ctrl    = ex_ctrl;
  assign bus.ex_pc      = ex_pc;
  assign bus.ex_rs_data = ex_rs_data;
  assign bus.ex_rt_data = ex_rt_data;
  assign bus.ex_imm     = ex_imm;
  assign bus.ex_rs      = ex_rs;
  assign bus.ex_rt      = ex_rt;
  assign bus.ex_shamt   = ex_shamt;
  assign bus.ex_wreg    = ex_wreg;
  assign bus.bubble_cnt = bubble_cnt;
endmodule
